program_ram: RTL and testbench

Parametrised program/data RAM for the 8-bit CPU: the next generation of the 16×8 bus-attached memory. It adds configurable data width and depth, an asynchronous active-low reset, a synchronised front-panel programming path with an auto-incrementing pointer, bus-contention detection, and an optional post-reset clear sweep. It sits on the shared tri-state CPU bus, addressed by the memory address register, and is loaded from board switches in manual mode.

---
 rtl/program_ram_pkg.sv | 13 +
 rtl/button_edge_sync.sv | 33 +++
 rtl/program_ram.sv | 137 +++++++++++++
 tb/tb_program_ram.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/program_ram_pkg.sv
// Shared types and defaults for the bus-attached program/data RAM.
package program_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int SYNC_STAGES        = 2;

endpackage

// File: rtl/button_edge_sync.sv
// Front-panel button synchroniser plus rising-edge detector: one pulse per press.
// Latency: pulse appears STAGES-1 edges after the first edge that samples the button high; no backpressure.
module button_edge_sync
  import program_ram_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], btn_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/program_ram.sv
// Program/data RAM on the tri-state CPU bus with front-panel programming; reads are combinational, writes commit on the strobe edge.
// Optional RAM_CLEAR_EN adds a post-reset zeroing sweep (busy high DEPTH cycles) during which all accesses are ignored.
module program_ram
  import program_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_from_bus,
  input  logic                  write_to_bus,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  manual_mode,
  input  logic                  manual_write,
  input  logic                  manual_addr_load,
  input  logic [DATA_WIDTH-1:0] program_switches,
  inout  wire  [DATA_WIDTH-1:0] bus,
  output logic [ADDR_WIDTH-1:0] manual_pointer,
  output logic                  busy,
  output logic                  bus_conflict
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  conflict_q, conflict_d;
  logic                  wr_pulse, ld_pulse;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  idle, cpu_wr, cpu_rd, man_ld, man_wr;

  button_edge_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (manual_write),
    .pulse_o(wr_pulse)
  );

  button_edge_sync #(.STAGES(SYNC_STAGES)) u_ld_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (manual_addr_load),
    .pulse_o(ld_pulse)
  );

`ifdef RAM_CLEAR_EN
  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = IDLE;
    end
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = clr_cnt_q;
  assign busy     = (state_q == CLEAR);
`else
  ram_state_t state_q;

  assign state_q  = IDLE;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  assign idle   = (state_q == IDLE);
  assign cpu_wr = idle && !manual_mode && read_from_bus && !write_to_bus;
  assign cpu_rd = idle && !manual_mode && write_to_bus && !read_from_bus;
  // Edges seen outside manual mode are consumed by the detector and dropped here.
  assign man_ld = idle && manual_mode && ld_pulse;
  assign man_wr = idle && manual_mode && wr_pulse && !ld_pulse;

  always_comb begin
    ptr_d      = ptr_q;
    conflict_d = conflict_q;
    if (man_ld)      ptr_d = address;
    else if (man_wr) ptr_d = ptr_q + 1'b1;
    if (!manual_mode && read_from_bus && write_to_bus) conflict_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = bus;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (man_wr) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = program_switches;
    end else if (cpu_wr) begin
      mem_we = 1'b1;
    end
  end

  // Contents are deliberately not reset; only the optional sweep zeroes them.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus            = cpu_rd ? mem_q[address] : {DATA_WIDTH{1'bz}};
  assign manual_pointer = ptr_q;
  assign bus_conflict   = conflict_q;

endmodule

// File: tb/tb_program_ram.sv
// Directed bench for program_ram: CPU bus access, front-panel programming, contention and optional clear sweep.
module tb_program_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       read_from_bus, write_to_bus;
  logic [3:0] address;
  logic       manual_mode, manual_write, manual_addr_load;
  logic [7:0] program_switches;
  wire  [7:0] bus;
  logic [3:0] manual_pointer;
  logic       busy, bus_conflict;
  logic       tb_oe;
  logic [7:0] tb_drv;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt;

  assign bus = tb_oe ? tb_drv : 8'hzz;

  always #5 clk = ~clk;

  program_ram dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .read_from_bus   (read_from_bus),
    .write_to_bus    (write_to_bus),
    .address         (address),
    .manual_mode     (manual_mode),
    .manual_write    (manual_write),
    .manual_addr_load(manual_addr_load),
    .program_switches(program_switches),
    .bus             (bus),
    .manual_pointer  (manual_pointer),
    .busy            (busy),
    .bus_conflict    (bus_conflict)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read a word over the bus with the CPU read strobe.
  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
    tb_oe        = 1'b0;
    address      = a;
    write_to_bus = 1'b1;
    #1;
    d            = bus;
    write_to_bus = 1'b0;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    tb_oe         = 1'b1;
    tb_drv        = d;
    address       = a;
    read_from_bus = 1'b1;
    tick(1);
    read_from_bus = 1'b0;
    tb_oe         = 1'b0;
  endtask

  task automatic press(input logic w, input logic l);
    manual_write     = w;
    manual_addr_load = l;
    tick(3);
    manual_write     = 1'b0;
    manual_addr_load = 1'b0;
    tick(3);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      tick(1);
    end
  endtask

  logic [7:0] rd;

  initial begin
    rst_n = 1'b0; read_from_bus = 1'b0; write_to_bus = 1'b0; address = '0;
    manual_mode = 1'b0; manual_write = 1'b0; manual_addr_load = 1'b0;
    program_switches = '0; tb_oe = 1'b0; tb_drv = '0;
    tick(3);
    chk("rst_pointer", 32'(manual_pointer), 32'h0);
    chk("rst_conflict", 32'(bus_conflict), 32'h0);
`ifdef RAM_CLEAR_EN
    chk("rst_busy", 32'(busy), 32'h1);
`else
    chk("rst_busy", 32'(busy), 32'h0);
`endif
    rst_n = 1'b1;
    count_busy(busy_cnt);
`ifdef RAM_CLEAR_EN
    chk("sweep_len", 32'(busy_cnt), 32'd16);
    cpu_read(4'd5, rd);
    chk("cleared_word5", 32'(rd), 32'h00);
`else
    chk("sweep_len", 32'(busy_cnt), 32'd0);
`endif

    // CPU writes and reads back
    cpu_write(4'd3, 8'hA5);
    cpu_write(4'd7, 8'h3C);
    cpu_write(4'd1, 8'hC3);
    cpu_read(4'd3, rd);
    chk("cpu_rd3", 32'(rd), 32'hA5);
    cpu_read(4'd7, rd);
    chk("cpu_rd7", 32'(rd), 32'h3C);
    // No strobe: RAM must not drive over the bench's 00
    tb_oe = 1'b1; tb_drv = 8'h00; address = 4'd3; #1;
    chk("no_strobe_undriven", 32'(bus), 32'h00);
    tb_oe = 1'b0;

    // Front-panel programming with pointer wrap
    manual_mode = 1'b1;
    address     = 4'd14;
    press(1'b0, 1'b1);
    chk("ptr_loaded", 32'(manual_pointer), 32'd14);
    program_switches = 8'h11; press(1'b1, 1'b0);
    chk("ptr_after_11", 32'(manual_pointer), 32'd15);
    program_switches = 8'h22; press(1'b1, 1'b0);
    chk("ptr_wrap", 32'(manual_pointer), 32'd0);
    program_switches = 8'h33; press(1'b1, 1'b0);
    chk("ptr_after_33", 32'(manual_pointer), 32'd1);
    // CPU strobes in manual mode: no drive, no conflict
    tb_oe = 1'b1; tb_drv = 8'h00; address = 4'd3; write_to_bus = 1'b1; #1;
    chk("manual_no_drive", 32'(bus), 32'h00);
    read_from_bus = 1'b1; tick(2);
    chk("manual_no_conflict", 32'(bus_conflict), 32'h0);
    read_from_bus = 1'b0; write_to_bus = 1'b0; tb_oe = 1'b0;
    // Load and write pressed together: load wins, write dropped
    address = 4'd3; program_switches = 8'h77;
    press(1'b1, 1'b1);
    chk("both_ptr", 32'(manual_pointer), 32'd3);
    manual_mode = 1'b0; tick(1);
    chk("ptr_kept_exit", 32'(manual_pointer), 32'd3);
    cpu_read(4'd14, rd); chk("man_data14", 32'(rd), 32'h11);
    cpu_read(4'd15, rd); chk("man_data15", 32'(rd), 32'h22);
    cpu_read(4'd0,  rd); chk("man_data0",  32'(rd), 32'h33);
    cpu_read(4'd1,  rd); chk("both_dropped_w1", 32'(rd), 32'hC3);
    cpu_read(4'd3,  rd); chk("both_dropped_w3", 32'(rd), 32'hA5);

    // Held button: one write, committed at the third edge
    manual_mode = 1'b1; program_switches = 8'h5E;
    manual_write = 1'b1;
    tick(1); chk("held_edge1", 32'(manual_pointer), 32'd3);
    tick(1); chk("held_edge2", 32'(manual_pointer), 32'd3);
    tick(1); chk("held_edge3", 32'(manual_pointer), 32'd4);
    tick(17); chk("held_20", 32'(manual_pointer), 32'd4);
    manual_write = 1'b0; tick(4);
    chk("held_release", 32'(manual_pointer), 32'd4);
    manual_mode = 1'b0; tick(1);
    cpu_read(4'd3, rd); chk("held_data3", 32'(rd), 32'h5E);

    // Contention: bench drives 5A, RAM holds 5E at address 3
    tb_oe = 1'b1; tb_drv = 8'h5A; address = 4'd3;
    read_from_bus = 1'b1; write_to_bus = 1'b1; #1;
    chk("conflict_no_drive", 32'(bus), 32'h5A);
    tick(1);
    chk("conflict_set", 32'(bus_conflict), 32'h1);
    read_from_bus = 1'b0; write_to_bus = 1'b0; tb_oe = 1'b0;
    tick(3);
    chk("conflict_sticky", 32'(bus_conflict), 32'h1);
    cpu_read(4'd3, rd); chk("conflict_mem_kept", 32'(rd), 32'h5E);
    rst_n = 1'b0; #1;
    chk("conflict_cleared", 32'(bus_conflict), 32'h0);
    chk("ptr_reset", 32'(manual_pointer), 32'd0);
    tick(1);
    rst_n = 1'b1;

`ifdef RAM_CLEAR_EN
    // Interrupt the sweep at word 7, then it must restart in full
    tick(7);
    rst_n = 1'b0; tick(1);
    chk("midsweep_busy", 32'(busy), 32'h1);
    rst_n = 1'b1;
    count_busy(busy_cnt);
    chk("resweep_len", 32'(busy_cnt), 32'd16);
    for (int a = 0; a < 16; a++) begin
      cpu_read(4'(a), rd);
      chk($sformatf("cleared_%0d", a), 32'(rd), 32'h00);
    end
`else
    tick(1);
    chk("no_sweep_busy", 32'(busy), 32'h0);
    cpu_read(4'd3, rd); chk("retained_data3", 32'(rd), 32'h5E);
    cpu_read(4'd14, rd); chk("retained_data14", 32'(rd), 32'h11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
